// File: rtl/issue_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : issue_pkg
//  Brief   : Shared issue-stage sizing constants used by issue_alloc and issue_fifo.
//  Rev     : 1.0  initial release
// ============================================================================
package issue_pkg;

   localparam int ISSUE_DATA_W     = 64;
   localparam int ISSUE_DEPTH_LOG2 = 8;
   localparam int ISSUE_CNT_W      = ISSUE_DEPTH_LOG2 + 1;

   typedef logic [ISSUE_CNT_W-1:0] issue_cnt_t;

endpackage
`default_nettype wire

// File: rtl/issue_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module  : issue_fifo_mem
//  Brief   : Simple dual-port array, synchronous write, asynchronous read.
//  Rev     : 1.0  initial release
// ============================================================================
module issue_fifo_mem
   import issue_pkg::*;
#(
   parameter int DATA_W = ISSUE_DATA_W,
   parameter int ADDR_W = ISSUE_DEPTH_LOG2
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   // Payload storage carries no reset; validity is tracked by the pointers.
   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (i_we) begin
         mem_q[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = mem_q[i_raddr];

endmodule
`default_nettype wire

// File: rtl/issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : issue_fifo
//  Brief   : First-word-fall-through issue queue with occupancy, full and
//            sticky overflow flags. ISSUE_FIFO_HWM_EN adds an o_hwm port.
//  Rev     : 1.0  initial release
// ============================================================================
module issue_fifo
   import issue_pkg::*;
#(
   parameter int DATA_W     = ISSUE_DATA_W,
   parameter int DEPTH_LOG2 = ISSUE_DEPTH_LOG2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                i_flush,
   input  logic                i_wen,
   input  logic [DATA_W-1:0]   i_wdata,
   output logic                o_valid,
   output logic [DATA_W-1:0]   o_rdata,
   input  logic                i_ready,
   output logic [DEPTH_LOG2:0] o_count,
   output logic                o_full,
`ifdef ISSUE_FIFO_HWM_EN
   output logic [DEPTH_LOG2:0] o_hwm,
`endif
   output logic                o_overflow
);

   localparam int               PTR_W  = DEPTH_LOG2 + 1;
   localparam logic [PTR_W-1:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
   localparam logic [PTR_W-1:0] C_ONE  = PTR_W'(1);

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             overflow_q, overflow_d;
   logic [PTR_W-1:0] count;
   logic             rd_fire;
   logic             wr_fire;

   // Flush masks both the read and the write so neither moves a pointer.
   always_comb begin
      count      = wptr_q - rptr_q;
      o_valid    = (count != '0);
      o_full     = (count == C_FULL);
      rd_fire    = o_valid & i_ready & ~i_flush;
      wr_fire    = i_wen & (~o_full | rd_fire) & ~i_flush;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      overflow_d = overflow_q;
      if (i_flush) begin
         wptr_d = rptr_q;
      end else begin
         if (rd_fire) begin
            rptr_d = rptr_q + C_ONE;
         end
         if (wr_fire) begin
            wptr_d = wptr_q + C_ONE;
         end
         if (i_wen & o_full & ~rd_fire) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q     <= '0;
         rptr_q     <= '0;
         overflow_q <= 1'b0;
      end else begin
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         overflow_q <= overflow_d;
      end
   end

   assign o_count    = count;
   assign o_overflow = overflow_q;

   issue_fifo_mem #(
      .DATA_W (DATA_W),
      .ADDR_W (DEPTH_LOG2)
   ) u_mem (
      .clk     (clk),
      .i_we    (wr_fire),
      .i_waddr (wptr_q[DEPTH_LOG2-1:0]),
      .i_wdata (i_wdata),
      .i_raddr (rptr_q[DEPTH_LOG2-1:0]),
      .o_rdata (o_rdata)
   );

`ifdef ISSUE_FIFO_HWM_EN
   logic [PTR_W-1:0] hwm_q, hwm_d;
   logic [PTR_W-1:0] next_count;

   // Tracks the post-edge occupancy so the mark moves together with o_count.
   always_comb begin
      next_count = wptr_d - rptr_d;
      hwm_d      = (next_count > hwm_q) ? next_count : hwm_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hwm_q <= '0;
      end else begin
         hwm_q <= hwm_d;
      end
   end

   assign o_hwm = hwm_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_issue_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_issue_fifo
//  Brief   : Scoreboard bench for issue_fifo (8 entries x 8 bits); directed
//            scenarios followed by randomized traffic against a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_issue_fifo;

   localparam int DW    = 8;
   localparam int DL2   = 3;
   localparam int DEPTH = 1 << DL2;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic           i_flush = 1'b0;
   logic           i_wen = 1'b0;
   logic [DW-1:0]  i_wdata = '0;
   logic           o_valid;
   logic [DW-1:0]  o_rdata;
   logic           i_ready = 1'b0;
   logic [DL2:0]   o_count;
   logic           o_full;
   logic           o_overflow;
`ifdef ISSUE_FIFO_HWM_EN
   logic [DL2:0]   o_hwm;
`endif

   issue_fifo #(.DATA_W(DW), .DEPTH_LOG2(DL2)) dut (
      .clk        (clk),
      .reset      (reset),
      .i_flush    (i_flush),
      .i_wen      (i_wen),
      .i_wdata    (i_wdata),
      .o_valid    (o_valid),
      .o_rdata    (o_rdata),
      .i_ready    (i_ready),
      .o_count    (o_count),
      .o_full     (o_full),
`ifdef ISSUE_FIFO_HWM_EN
      .o_hwm      (o_hwm),
`endif
      .o_overflow (o_overflow)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference state: expected payloads in order plus occupancy-level flags.
   logic [DW-1:0] exp_q[$];
   int            m_count = 0;
   bit            m_ovf   = 1'b0;
   int            m_hwm   = 0;
   bit            mon_en  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Apply one cycle of inputs, then advance the model across the edge.
   task automatic step(input bit w, input logic [DW-1:0] d, input bit rdy, input bit fl, input bit rs);
      bit rdf, wrf;
      reset   = rs;
      i_flush = fl;
      i_wen   = w;
      i_wdata = d;
      i_ready = rdy;
      @(posedge clk);
      if (rs) begin
         m_count = 0;
         m_ovf   = 1'b0;
         m_hwm   = 0;
         exp_q.delete();
      end else if (fl) begin
         m_count = 0;
         exp_q.delete();
      end else begin
         rdf = (m_count != 0) && rdy;
         wrf = w && ((m_count != DEPTH) || rdf);
         if (wrf) exp_q.push_back(d);
         if (w && (m_count == DEPTH) && !rdf) m_ovf = 1'b1;
         m_count = m_count + int'(wrf) - int'(rdf);
         if (m_count > m_hwm) m_hwm = m_count;
      end
      #1;
   endtask

   // Monitor: status every cycle, payload popped whenever a read is about to fire.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      if (mon_en) begin
         check("valid", 32'(o_valid), 32'(m_count != 0));
         check("count", 32'(o_count), 32'(m_count));
         check("full", 32'(o_full), 32'(m_count == DEPTH));
         check("overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef ISSUE_FIFO_HWM_EN
         check("hwm", 32'(o_hwm), 32'(m_hwm));
`endif
         if (o_valid && i_ready && !i_flush && !reset) begin
            if (exp_q.size() == 0) begin
               check("read_when_model_empty", 32'(o_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("rdata", 32'(o_rdata), 32'(e));
            end
         end
      end
   end

   initial begin
      int rdy_pct;
      // Scenario 1: single write becomes visible one cycle later.
      step(0, 8'h00, 0, 0, 1);
      mon_en = 1'b1;
      check("t0_reset_count", 32'(o_count), 32'd0);
      check("t0_reset_valid", 32'(o_valid), 32'd0);
      step(1, 8'h11, 0, 0, 0);
      check("t1_valid", 32'(o_valid), 32'd1);
      check("t1_rdata", 32'(o_rdata), 32'h11);
      check("t1_count", 32'(o_count), 32'd1);

      // Scenario 2: fill, then one dropped write.
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
      check("t2_count", 32'(o_count), 32'd8);
      check("t2_full", 32'(o_full), 32'd1);
      step(1, 8'hEE, 0, 0, 0);
      check("t2_overflow", 32'(o_overflow), 32'd1);
      check("t2_count_hold", 32'(o_count), 32'd8);

      // Scenario 3: simultaneous read/write while full.
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h30 + i), 0, 0, 0);
      step(1, 8'hAA, 1, 0, 0);
      check("t3_count", 32'(o_count), 32'd8);
      check("t3_overflow", 32'(o_overflow), 32'd0);
      for (int i = 0; i < DEPTH - 1; i++) step(0, 8'h00, 1, 0, 0);
      check("t3_head_aa", 32'(o_rdata), 32'hAA);
      step(0, 8'h00, 1, 0, 0);

      // Scenario 4: streaming through pointer wrap.
      for (int i = 0; i < 20; i++) begin
         step(1, 8'(i), 1, 0, 0);
         check("t4_count_le1", 32'(o_count <= 1), 32'd1);
      end
      step(0, 8'h00, 1, 0, 0);

      // Scenario 5: flush beats a same-cycle write.
      for (int i = 0; i < 5; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
      step(1, 8'h5F, 0, 1, 0);
      check("t5_count", 32'(o_count), 32'd0);
      check("t5_valid", 32'(o_valid), 32'd0);
      check("t5_overflow", 32'(o_overflow), 32'd0);
      step(1, 8'h77, 0, 0, 0);
      check("t5_rdata", 32'(o_rdata), 32'h77);
      step(0, 8'h00, 1, 0, 0);

`ifdef ISSUE_FIFO_HWM_EN
      // Scenario 6: high-water mark survives reads and flush, clears on reset.
      step(0, 8'h00, 0, 0, 1);
      for (int i = 0; i < 6; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
      check("t6_hwm_fill", 32'(o_hwm), 32'd6);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 0, 0);
      step(0, 8'h00, 0, 1, 0);
      step(1, 8'h70, 0, 0, 0);
      step(1, 8'h71, 0, 0, 0);
      check("t6_hwm_after", 32'(o_hwm), 32'd6);
      step(0, 8'h00, 0, 0, 1);
      check("t6_hwm_reset", 32'(o_hwm), 32'd0);
`endif

      // Randomized traffic with varying drain pressure, rare flush and reset.
      step(0, 8'h00, 0, 0, 1);
      rdy_pct = 50;
      for (int c = 0; c < 1500; c++) begin
         if (c % 60 == 0) rdy_pct = int'($urandom_range(0, 100));
         step(($urandom_range(0, 99) < 60),
              8'($urandom),
              (int'($urandom_range(0, 99)) < rdy_pct),
              ($urandom_range(0, 49) == 0),
              ($urandom_range(0, 299) == 0));
      end

      // Drain and confirm every accepted payload came out.
      for (int c = 0; c < DEPTH + 2; c++) step(0, 8'h00, 1, 0, 0);
      check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
